// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: start/done, register-bus and PC-load signals of the branch sequencer; BRANCH_STATS_EN adds counters
interface branch_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int REG_SEL_W = 4
`ifdef BRANCH_STATS_EN
    , parameter int STAT_W = 16
`endif
);
    logic                 start;
    logic [DATA_W-1:0]    ir_in;
    logic [DATA_W-1:0]    pc_in;
    logic [REG_SEL_W-1:0] ra_sel;
    logic                 ra_req;
    logic [DATA_W-1:0]    ra_value;
    logic [DATA_W-1:0]    pc_out;
    logic                 pc_load;
    logic                 taken;
    logic                 illegal;
    logic                 busy;
    logic                 done;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0]    stat_taken;
    logic [STAT_W-1:0]    stat_not_taken;
`endif
    modport master (
        output start, ir_in, pc_in, ra_value,
        input  ra_sel, ra_req, pc_out, pc_load, taken, illegal, busy, done
`ifdef BRANCH_STATS_EN
        , input stat_taken, stat_not_taken
`endif
    );
    modport slave (
        input  start, ir_in, pc_in, ra_value,
        output ra_sel, ra_req, pc_out, pc_load, taken, illegal, busy, done
`ifdef BRANCH_STATS_EN
        , output stat_taken, stat_not_taken
`endif
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: four-cycle conditional branch FSM (SEL, EVAL, UPDATE, DONE); BRANCH_STATS_EN adds taken/not-taken counters
module branch_sequencer #(
    parameter int DATA_W = 32,
    parameter int OFFSET_W = 19,
    parameter int REG_SEL_W = 4
`ifdef BRANCH_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input logic clk,
    input logic clr,
    branch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEL, EVAL, UPDATE, DONE} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d, pc_q, pc_d, pc_out_q, pc_out_d, target;
    logic [REG_SEL_W-1:0] ra_sel_q, ra_sel_d;
    logic ra_req_q, ra_req_d, pc_load_q, pc_load_d, taken_q, taken_d;
    logic illegal_q, illegal_d, busy_q, busy_d, done_q, done_d;
    logic accept, eval, zero, neg, hit, unused_ir;
    logic [7:0] cond_hit;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_taken_q, stat_taken_d, stat_not_taken_q, stat_not_taken_d;
`endif
    assign unused_ir = ^ir_q[DATA_W-1:OFFSET_W+4];
    always_comb begin
        zero = bus.ra_value == '0;
        neg = bus.ra_value[DATA_W-1];
        cond_hit = {!neg, zero || neg, 1'b0, 1'b1, neg, !neg && !zero, !zero, zero};
        hit = !ir_q[OFFSET_W+3] && cond_hit[ir_q[OFFSET_W+2:OFFSET_W]];
        target = pc_q + {{(DATA_W-OFFSET_W){ir_q[OFFSET_W-1]}}, ir_q[OFFSET_W-1:0]};
        case (state_q)
            IDLE:    state_d = bus.start ? SEL : IDLE;
            SEL:     state_d = EVAL;
            EVAL:    state_d = UPDATE;
            UPDATE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
        accept = state_q == IDLE && bus.start;
        eval = state_q == EVAL;
        ir_d = accept ? bus.ir_in : ir_q;
        pc_d = accept ? bus.pc_in : pc_q;
        ra_sel_d = accept ? bus.ir_in[OFFSET_W+4 +: REG_SEL_W] : ra_sel_q;
        taken_d = eval ? hit : taken_q;
        illegal_d = eval ? ir_q[OFFSET_W+3] : illegal_q;
        pc_out_d = eval ? (hit ? target : pc_q) : pc_out_q;
        ra_req_d = state_d == SEL;
        pc_load_d = state_d == UPDATE;
        done_d = state_d == DONE;
        busy_d = state_d != IDLE;
`ifdef BRANCH_STATS_EN
        stat_taken_d = done_q && taken_q && !(&stat_taken_q) ? stat_taken_q + 1'b1 : stat_taken_q;
        stat_not_taken_d = done_q && !taken_q && !(&stat_not_taken_q) ? stat_not_taken_q + 1'b1 : stat_not_taken_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ir_q <= '0;
            pc_q <= '0;
            pc_out_q <= '0;
            ra_sel_q <= '0;
            ra_req_q <= 1'b0;
            pc_load_q <= 1'b0;
            taken_q <= 1'b0;
            illegal_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef BRANCH_STATS_EN
            stat_taken_q <= '0;
            stat_not_taken_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            pc_q <= pc_d;
            pc_out_q <= pc_out_d;
            ra_sel_q <= ra_sel_d;
            ra_req_q <= ra_req_d;
            pc_load_q <= pc_load_d;
            taken_q <= taken_d;
            illegal_q <= illegal_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef BRANCH_STATS_EN
            stat_taken_q <= stat_taken_d;
            stat_not_taken_q <= stat_not_taken_d;
`endif
        end
    end
    assign bus.ra_sel = ra_sel_q;
    assign bus.ra_req = ra_req_q;
    assign bus.pc_out = pc_out_q;
    assign bus.pc_load = pc_load_q;
    assign bus.taken = taken_q;
    assign bus.illegal = illegal_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef BRANCH_STATS_EN
    assign bus.stat_taken = stat_taken_q;
    assign bus.stat_not_taken = stat_not_taken_q;
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed branches with a queued-expectation monitor on ra_req/pc_load/done
module tb_branch_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;
`ifdef BRANCH_STATS_EN
    branch_sequencer_if #(.DATA_W(32), .REG_SEL_W(4), .STAT_W(3)) bus ();
    branch_sequencer #(.DATA_W(32), .OFFSET_W(19), .REG_SEL_W(4), .STAT_W(3)) dut (.clk(clk), .clr(clr), .bus(bus));
`else
    branch_sequencer_if #(.DATA_W(32), .REG_SEL_W(4)) bus ();
    branch_sequencer #(.DATA_W(32), .OFFSET_W(19), .REG_SEL_W(4)) dut (.clk(clk), .clr(clr), .bus(bus));
`endif
    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic        il;
        logic        abort;
        logic [3:0]  ra;
        int          c0;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [2:0] tab [8];
    logic [31:0] rv [3];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [3:0] cond, input logic [3:0] ra, input logic [18:0] c);
        return {5'b11011, ra, cond, c};
    endfunction

    always @(negedge clk) if (!clr) begin
        if (bus.ra_req) begin
            if (q.size() == 0) chk("unexpected ra_req", {31'b0, bus.ra_req}, 0);
            else begin
                chk("ra_sel", {28'b0, bus.ra_sel}, {28'b0, q[0].ra});
                chk("ra_req cycle", cyc, q[0].c0 + 1);
            end
        end
        if (bus.pc_load) begin
            if (q.size() == 0 || q[0].abort) chk("unexpected pc_load", {31'b0, bus.pc_load}, 0);
            else begin
                chk("pc_out", bus.pc_out, q[0].pc);
                chk("pc_load cycle", cyc, q[0].c0 + 3);
            end
        end
        if (bus.done) begin
            if (q.size() == 0 || q[0].abort) chk("unexpected done", {31'b0, bus.done}, 0);
            else begin
                chk("taken", {31'b0, bus.taken}, {31'b0, q[0].t});
                chk("illegal", {31'b0, bus.illegal}, {31'b0, q[0].il});
                chk("done cycle", cyc, q[0].c0 + 4);
                void'(q.pop_front());
            end
        end
    end

    task automatic run(input logic [3:0] cond, input logic [3:0] ra_f, input logic [18:0] c,
                       input logic [31:0] pc, input logic [31:0] ra, input logic [31:0] exp_pc,
                       input logic et, input logic ei, input bit restart = 0);
        logic [31:0] ir;
        ir = mk_ir(cond, ra_f, c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.ir_in = ir;
        bus.pc_in = pc;
        bus.ra_value = ~ra;
        q.push_back('{pc: exp_pc, t: et, il: ei, abort: 1'b0, ra: ra_f, c0: cyc});
        @(negedge clk);
        bus.start = restart;
        bus.ir_in = ~ir;
        bus.pc_in = ~pc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ra_value = ra;
        @(negedge clk);
        bus.ra_value = ~ra;
        @(negedge clk);
    endtask

    task automatic abort_eval();
        @(negedge clk);
        bus.start = 1'b1;
        bus.ir_in = mk_ir(4'd4, 4'd3, 19'd1);
        bus.pc_in = 32'h500;
        bus.ra_value = 32'h0;
        q.push_back('{pc: 32'h0, t: 1'b0, il: 1'b0, abort: 1'b1, ra: 4'd3, c0: cyc});
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("busy after clr", {31'b0, bus.busy}, 0);
        chk("pc_load after clr", {31'b0, bus.pc_load}, 0);
        chk("done after clr", {31'b0, bus.done}, 0);
        chk("pc_out after clr", bus.pc_out, 0);
        void'(q.pop_front());
        @(negedge clk);
        chk("idle after clr", {31'b0, bus.busy}, 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tab = '{3'b100, 3'b011, 3'b010, 3'b001, 3'b111, 3'b000, 3'b101, 3'b110};
        rv = '{32'h0, 32'h1, 32'h8000_0000};
        bus.start = 1'b1;
        bus.ir_in = 32'hFFFF_FFFF;
        bus.pc_in = 32'h1234_5678;
        bus.ra_value = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'b0, bus.busy}, 0);
        chk("reset done", {31'b0, bus.done}, 0);
        chk("reset pc_load", {31'b0, bus.pc_load}, 0);
        chk("reset ra_req", {31'b0, bus.ra_req}, 0);
        chk("reset taken", {31'b0, bus.taken}, 0);
        chk("reset illegal", {31'b0, bus.illegal}, 0);
        chk("reset pc_out", bus.pc_out, 0);
        chk("reset ra_sel", {28'b0, bus.ra_sel}, 0);
        clr = 1'b0;
        bus.start = 1'b0;
        run(4'd0, 4'd0, 19'h1FF, 32'h10, 32'h12, 32'h10, 1'b0, 1'b0);
        run(4'd0, 4'd0, 19'h1FF, 32'h10, 32'h0, 32'h20F, 1'b1, 1'b0);
        run(4'd1, 4'd2, 19'h7FFFF, 32'h100, 32'h5, 32'hFF, 1'b1, 1'b0);
        run(4'd4, 4'd7, 19'h1, 32'hFFFF_FFFF, 32'h1234, 32'h0, 1'b1, 1'b0);
        run(4'd7, 4'd1, 19'h40000, 32'h10_0000, 32'h7, 32'hC_0000, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++)
            for (int j = 0; j < 3; j++)
                run(c[3:0], c[3:0], 19'h40, 32'h1000, rv[j],
                    tab[c][2-j] ? 32'h1040 : 32'h1000, tab[c][2-j], 1'b0);
        run(4'd8, 4'd5, 19'h5, 32'h30, 32'h0, 32'h30, 1'b0, 1'b1);
        run(4'd15, 4'd9, 19'h7FFFF, 32'h30, 32'h8000_0000, 32'h30, 1'b0, 1'b1);
        run(4'd4, 4'd6, 19'h10, 32'h200, 32'h0, 32'h210, 1'b1, 1'b0, 1);
        abort_eval();
        run(4'd3, 4'd4, 19'h20, 32'h400, 32'h8000_0000, 32'h420, 1'b1, 1'b0);
`ifdef BRANCH_STATS_EN
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("stat_taken cleared", {29'b0, bus.stat_taken}, 0);
        chk("stat_not_taken cleared", {29'b0, bus.stat_not_taken}, 0);
        repeat (3) run(4'd4, 4'd1, 19'h4, 32'h40, 32'h0, 32'h44, 1'b1, 1'b0);
        run(4'd5, 4'd1, 19'h4, 32'h40, 32'h0, 32'h40, 1'b0, 1'b0);
        run(4'd8, 4'd1, 19'h4, 32'h40, 32'h0, 32'h40, 1'b0, 1'b1);
        @(negedge clk);
        chk("stat_taken", {29'b0, bus.stat_taken}, 3);
        chk("stat_not_taken", {29'b0, bus.stat_not_taken}, 2);
        repeat (6) run(4'd4, 4'd1, 19'h4, 32'h40, 32'h0, 32'h44, 1'b1, 1'b0);
        @(negedge clk);
        chk("stat_taken saturated", {29'b0, bus.stat_taken}, 7);
        chk("stat_not_taken held", {29'b0, bus.stat_not_taken}, 2);
`endif
        repeat (3) @(negedge clk);
        chk("queue drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Parametrised multi-cycle conditional-branch controller for the bus-based datapath.
- Sequences branch execution over four cycles:
  - selects Ra onto the bus,
  - evaluates the condition field of IR,
  - computes the target PC + sign-extended C,
  - pulses a PC load.
- Replaces hand-sequenced branch control signals with a self-contained FSM, a start/done handshake and an extended condition set.

Parameters:
- DATA_W, 32, width of IR, Ra value and PC.
- OFFSET_W, 19, width of the IR constant field C, in IR[OFFSET_W-1:0].
- REG_SEL_W, 4, width of the Ra field, in IR[OFFSET_W+4+REG_SEL_W-1 : OFFSET_W+4].
- STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  request to execute the branch held in ir_in; sampled only in IDLE.
- ir_in  in  DATA_W  instruction register contents; captured on accepted start.
- pc_in  in  DATA_W  current PC (already incremented); captured on accepted start.
- ra_sel  out  REG_SEL_W  Ra index presented to the register-out decoder.
- ra_req  out  1  asks the datapath to drive register ra_sel onto the bus.
- ra_value  in  DATA_W  bus value; sampled in the cycle after ra_req.
- pc_out  out  DATA_W  next PC value.
- pc_load  out  1  one-cycle strobe: PC <= pc_out.
- taken  out  1  branch outcome; valid while done=1.
- illegal  out  1  condition code unsupported; valid while done=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values (clr=1 at a clock edge): state=IDLE, and ra_req, pc_load, taken, illegal, busy, done all 0.
  - ra_sel=0 and pc_out=0.
  - Internal ir/pc/ra latches cleared.
- IR decode:
  - C = IR[OFFSET_W-1:0], sign-extended to DATA_W.
  - cond = IR[OFFSET_W+3:OFFSET_W].
  - Ra field as given under Parameters.
- FSM (one transition per clock):
  - IDLE: if start=1, latch ir_in and pc_in, then go to SEL. Otherwise stay.
  - SEL: ra_req=1; ra_sel = latched Ra field; go to EVAL.
  - EVAL: sample ra_value, compute taken and illegal, compute target = pc_lat + sext(C) modulo 2^DATA_W; go to UPDATE.
  - UPDATE: pc_out = taken ? target : pc_lat; pc_load=1 for this cycle only; go to DONE.
  - DONE: done=1 and taken/illegal valid; go to IDLE.
- Latency: start sampled at edge N, then pc_load high during cycle N+3 and done high during cycle N+4. The next start is accepted at edge N+5.
- Condition codes (cond[3:0]):
  - 0000: taken if Ra == 0.
  - 0001: taken if Ra != 0.
  - 0010: taken if Ra[DATA_W-1]==0 and Ra != 0 (strictly positive).
  - 0011: taken if Ra[DATA_W-1]==1 (negative).
  - 0100: always taken.
  - 0101: never taken.
  - 0110: taken if Ra == 0 or Ra[DATA_W-1]==1 (<= 0).
  - 0111: taken if Ra[DATA_W-1]==0 (>= 0).
  - 1xxx: illegal=1, taken=0, pc_out=pc_lat. pc_load still pulses.
- Boundary conditions:
  - start while busy is ignored, with no queuing.
  - ir_in/pc_in changing after the start edge have no effect.
  - PC addition wraps silently (0xFFFFFFFF + 1 = 0).
  - clr in any state returns to IDLE on that edge. pc_load and done are not issued, and clr wins over a simultaneous start.
  - ra_value is ignored outside EVAL.
- Outputs are registered; no combinational path from start to any output.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_taken [STAT_W] and stat_not_taken [STAT_W].
  - Each counter increments by 1 on the cycle done=1, according to taken. Illegal codes count as not taken.
  - Both counters saturate at all-ones and clear on clr.
- Undefined: the ports and counters do not exist, and the FSM is unchanged.

Test Plan:
- Zero compare, not taken: clr, then start with ir_in=0xD80001FF (cond 0000, Ra=0, C=0x1FF), pc_in=0x10, ra_value=0x12 -> pc_load at N+3, pc_out=0x10, done at N+4, taken=0.
- Zero compare, taken: same ir_in with ra_value=0x0 -> pc_out=0x20F, taken=1.
- Negative offset and wrap:
  - cond 0001, C=0x7FFFF (-1), ra_value=5, pc_in=0x100 -> pc_out=0xFF.
  - cond 0100, C=1, pc_in=0xFFFFFFFF -> pc_out=0x0.
- Full condition sweep: each cond 0000-0111 against ra_value in {0x0, 0x1, 0x80000000} -> taken matches the table. cond 1000 -> illegal=1, taken=0, pc_out=pc_in.
- Handshake/reset:
  - start pulsed again in SEL is ignored (single done).
  - clr asserted in EVAL -> busy=0 next cycle, no pc_load, no done.
  - start accepted again at N+5.
- BRANCH_STATS_EN: 3 taken + 2 not-taken branches -> stat_taken=3, stat_not_taken=2. Force counters near saturation -> they hold at 0xFFFF.
